simon_128256_core: RTL and testbench

- Iterative SIMON 128/256 block cipher core (64-bit words, 4-word key, 72 rounds) that encrypts or decrypts one 128-bit block at a time.
- Expands the 256-bit key into a stored round-key schedule, then runs one round per clock.
- Sits between a host that supplies blocks and keys through level handshakes and a consumer that reads results with a read strobe.

---
 rtl/simon_pkg.sv | 37 +++
 rtl/simon_128256_core_if.sv | 30 +++
 rtl/simon_key_expand.sv | 70 +++++++
 rtl/simon_128256_core.sv | 119 +++++++++++
 tb/tb_simon_128256_core.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON 128/256 core.
// Holds the default word, key-word and round counts, the z4 constant
// sequence used by the key schedule, the FSM state encoding (its values are
// the externally visible mode codes), and the rotate and round-function helpers.
package simon_pkg;

    localparam int SIMON_N = 64;
    localparam int SIMON_M = 4;
    localparam int SIMON_T = 72;

    // z4 sequence, index 0 is the MSB.
    localparam logic [61:0] Z4 =
        62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_KEYEXP = 4'd1,
        S_READY  = 4'd2,
        S_RUN    = 4'd3,
        S_DONE   = 4'd4
    } state_t;

    function automatic logic [SIMON_N-1:0] rol(input logic [SIMON_N-1:0] x,
                                               input int unsigned s);
        return (x << s) | (x >> (SIMON_N - s));
    endfunction

    function automatic logic [SIMON_N-1:0] ror(input logic [SIMON_N-1:0] x,
                                               input int unsigned s);
        return (x >> s) | (x << (SIMON_N - s));
    endfunction

    function automatic logic [SIMON_N-1:0] f(input logic [SIMON_N-1:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

endpackage

// File: rtl/simon_128256_core_if.sv
// Host/consumer handshake bundle for simon_128256_core.
//   master: host side (drives requests, BLOCK, KEY, readData)
//   slave : core side (drives load pulses, done levels, outData, mode)
interface simon_128256_core_if #(
    parameter int N = simon_pkg::SIMON_N,
    parameter int M = simon_pkg::SIMON_M
);
    logic                 newData;
    logic                 newKey;
    logic                 enc_dec;
    logic                 readData;
    logic [1:0][N-1:0]    BLOCK;
    logic [M-1:0][N-1:0]  KEY;
    logic                 loadData;
    logic                 loadKey;
    logic                 doneData;
    logic                 doneKey;
    logic [1:0][N-1:0]    outData;
    logic [3:0]           mode;

    modport master (
        output newData, newKey, enc_dec, readData, BLOCK, KEY,
        input  loadData, loadKey, doneData, doneKey, outData, mode
    );

    modport slave (
        input  newData, newKey, enc_dec, readData, BLOCK, KEY,
        output loadData, loadKey, doneData, doneKey, outData, mode
    );
endinterface

// File: rtl/simon_key_expand.sv
// SIMON 128/256 key schedule: captures the four key words on start, then
// derives one round key per cycle for T-M cycles into a T-entry store.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (aborts expansion)
//   start     : capture key and begin expansion
//   key       : key words, key[0] = k0
//   rd_idx    : round index for the read port
//   rd_key    : round key store[rd_idx]
//   last      : high during the cycle that writes the final round key
module simon_key_expand
    import simon_pkg::*;
#(
    parameter int N  = SIMON_N,
    parameter int M  = SIMON_M,
    parameter int T  = SIMON_T,
    parameter int Co = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [M-1:0][N-1:0] key,
    input  logic [Co-1:0]       rd_idx,
    output logic [N-1:0]        rd_key,
    output logic                last
);

    logic [N-1:0]  store [T];
    logic [Co-1:0] cnt;
    logic          busy;
    logic [5:0]    zi;
    logic [5:0]    zsel;
    logic          zbit;
    logic [N-1:0]  tmp;
    logic [N-1:0]  next_key;

    always_comb begin
        zi       = (cnt >= Co'(62)) ? 6'(cnt - Co'(62)) : cnt[5:0];
        zsel     = 6'd61 - zi;
        zbit     = Z4[zsel];
        tmp      = ror(store[cnt + Co'(3)], 3) ^ store[cnt + Co'(1)];
        tmp      = tmp ^ ror(tmp, 1);
        next_key = ~store[cnt] ^ tmp ^ N'(zbit) ^ N'(3);
    end

    assign last   = busy && (cnt == Co'(T - M - 1));
    assign rd_key = store[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (last) busy <= 1'b0;
            else      cnt  <= cnt + Co'(1);
        end
    end

    // Key store carries no reset; validity is tracked by the FSM's doneKey.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int unsigned i = 0; i < M; i++) store[Co'(i)] <= key[i];
        end else if (busy && !rst) begin
            store[cnt + Co'(M)] <= next_key;
        end
    end

endmodule

// File: rtl/simon_128256_core.sv
// Iterative SIMON 128/256 encrypt/decrypt core, one round per clock.
// Ports:
//   clk : clock
//   nR  : synchronous active-high reset
//   bus : handshake bundle (slave side) - newData/newKey/enc_dec/readData,
//         BLOCK/KEY in; loadData/loadKey pulses, doneData/doneKey levels,
//         outData, mode (state code) out
module simon_128256_core
    import simon_pkg::*;
#(
    parameter int N  = SIMON_N,
    parameter int M  = SIMON_M,
    parameter int T  = SIMON_T,
    parameter int Co = 7
) (
    input  logic                  clk,
    input  logic                  nR,
    simon_128256_core_if.slave    bus
);

    state_t            state;
    logic [N-1:0]      x, y, rk;
    logic [N-1:0]      x_nxt, y_nxt;
    logic              enc;
    logic [Co-1:0]     round;
    logic              key_start;
    logic              ks_last;
    logic              run_last;
    logic              ld_data, ld_key, done_data, done_key;
    logic [1:0][N-1:0] out_q;

    assign key_start = !nR && bus.newKey &&
                       (state == S_IDLE || state == S_READY || state == S_DONE);

    simon_key_expand #(.N(N), .M(M), .T(T), .Co(Co)) u_key (
        .clk    (clk),
        .rst    (nR),
        .start  (key_start),
        .key    (bus.KEY),
        .rd_idx (round),
        .rd_key (rk),
        .last   (ks_last)
    );

    always_comb begin
        if (enc) begin
            x_nxt = y ^ f(x) ^ rk;
            y_nxt = x;
        end else begin
            x_nxt = y;
            y_nxt = x ^ f(y) ^ rk;
        end
    end

    assign run_last = enc ? (round == Co'(T - 1)) : (round == '0);

    always_ff @(posedge clk) begin
        if (nR) begin
            state     <= S_IDLE;
            ld_data   <= 1'b0;
            ld_key    <= 1'b0;
            done_data <= 1'b0;
            done_key  <= 1'b0;
            out_q     <= '0;
            x         <= '0;
            y         <= '0;
            enc       <= 1'b0;
            round     <= '0;
        end else begin
            ld_data <= 1'b0;
            ld_key  <= 1'b0;
            case (state)
                S_IDLE, S_READY, S_DONE: begin
                    if (key_start) begin
                        ld_key   <= 1'b1;
                        done_key <= 1'b0;
                        state    <= S_KEYEXP;
                    end else if (state == S_READY && done_key && !done_data &&
                                 bus.newData) begin
                        x       <= bus.BLOCK[1];
                        y       <= bus.BLOCK[0];
                        enc     <= bus.enc_dec;
                        round   <= bus.enc_dec ? '0 : Co'(T - 1);
                        ld_data <= 1'b1;
                        state   <= S_RUN;
                    end else if (state == S_DONE && bus.readData) begin
                        done_data <= 1'b0;
                        state     <= S_READY;
                    end
                end
                S_KEYEXP: begin
                    if (ks_last) begin
                        done_key <= 1'b1;
                        state    <= done_data ? S_DONE : S_READY;
                    end
                end
                S_RUN: begin
                    x     <= x_nxt;
                    y     <= y_nxt;
                    round <= enc ? round + Co'(1) : round - Co'(1);
                    if (run_last) begin
                        out_q     <= {x_nxt, y_nxt};
                        done_data <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.loadData = ld_data;
    assign bus.loadKey  = ld_key;
    assign bus.doneData = done_data;
    assign bus.doneKey  = done_key;
    assign bus.outData  = out_q;
    assign bus.mode     = state;

endmodule

// File: tb/tb_simon_128256_core.sv
// Directed testbench for simon_128256_core: reset, key expansion, known-answer
// encrypt/decrypt, streaming with held requests, and reset during a run.
module tb_simon_128256_core;

    typedef logic [1:0][63:0] blk_t;
    typedef logic [3:0][63:0] key_t;

    localparam key_t KEY0 = {64'h1F1E1D1C1B1A1918, 64'h1716151413121110,
                             64'h0F0E0D0C0B0A0908, 64'h0706050403020100};
    localparam blk_t PT0  = {64'h74206E69206D6F6F, 64'h6D69732061207369};
    localparam blk_t CT0  = {64'h8D2B5579AFC8A3A0, 64'h3BF72A87EFE7B868};

    logic clk = 1'b0;
    logic nR;
    always #5 clk = ~clk;

    simon_128256_core_if bus ();

    simon_128256_core dut (
        .clk (clk),
        .nR  (nR),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Independent behavioural SIMON 128/256.
    function automatic blk_t simon_model(input key_t k, input blk_t blk, input bit encr);
        logic [63:0] ks [72];
        logic [63:0] a, b, t, fx;
        logic [61:0] z;
        z = 62'b11010001111001101011011000100000010111000011001010010011101111;
        for (int i = 0; i < 4; i++) ks[i] = k[i];
        for (int i = 0; i < 68; i++) begin
            a = ks[i+3];
            t = {a[2:0], a[63:3]} ^ ks[i+1];
            t = t ^ {t[0], t[63:1]};
            ks[i+4] = ~ks[i] ^ t ^ {63'd0, z[61 - (i % 62)]} ^ 64'd3;
        end
        a = blk[1];
        b = blk[0];
        if (encr) begin
            for (int i = 0; i < 72; i++) begin
                fx = ({a[62:0], a[63]} & {a[55:0], a[63:56]}) ^ {a[61:0], a[63:62]};
                t = a;
                a = b ^ fx ^ ks[i];
                b = t;
            end
        end else begin
            for (int i = 71; i >= 0; i--) begin
                fx = ({b[62:0], b[63]} & {b[55:0], b[63:56]}) ^ {b[61:0], b[63:62]};
                t = b;
                b = a ^ fx ^ ks[i];
                a = t;
            end
        end
        return {a, b};
    endfunction

    // Stimulus helpers (no checking). Called right after a negedge.
    task automatic do_key(input key_t k, output int nload, output int lat);
        bus.KEY = k;
        bus.newKey = 1'b1;
        nload = 0;
        lat = -1;
        for (int i = 0; i < 10 && nload == 0; i++) begin
            @(negedge clk);
            if (bus.loadKey) nload++;
        end
        bus.newKey = 1'b0;
        if (nload == 0) return;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.loadKey) nload++;
            if (bus.doneKey) begin lat = i; break; end
        end
    endtask

    task automatic do_block(input blk_t b, input logic e, output int nload, output int lat);
        bus.BLOCK = b;
        bus.enc_dec = e;
        bus.newData = 1'b1;
        nload = 0;
        lat = -1;
        for (int i = 0; i < 20 && nload == 0; i++) begin
            @(negedge clk);
            if (bus.loadData) nload++;
        end
        bus.newData = 1'b0;
        if (nload == 0) return;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.loadData) nload++;
            if (bus.doneData) begin lat = i; break; end
        end
    endtask

    task automatic read_pulse();
        bus.readData = 1'b1;
        @(negedge clk);
        bus.readData = 1'b0;
    endtask

    task automatic test_reset();
        nR = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.loadData !== 1'b0) begin n_err++; $display("FAIL reset_loadData: got %b want 0", bus.loadData); end
        n_cmp++; if (bus.loadKey !== 1'b0) begin n_err++; $display("FAIL reset_loadKey: got %b want 0", bus.loadKey); end
        n_cmp++; if (bus.doneData !== 1'b0) begin n_err++; $display("FAIL reset_doneData: got %b want 0", bus.doneData); end
        n_cmp++; if (bus.doneKey !== 1'b0) begin n_err++; $display("FAIL reset_doneKey: got %b want 0", bus.doneKey); end
        n_cmp++; if (bus.outData !== 128'd0) begin n_err++; $display("FAIL reset_outData: got %h want 0", bus.outData); end
        n_cmp++; if (bus.mode !== 4'd0) begin n_err++; $display("FAIL reset_mode: got %0d want 0", bus.mode); end
        nR = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_key_expand();
        int nload, lat, mode_bad;
        bus.KEY = KEY0;
        bus.newKey = 1'b1;
        @(negedge clk);
        nload = bus.loadKey ? 1 : 0;
        bus.newKey = 1'b0;
        lat = -1;
        mode_bad = 0;
        for (int i = 1; i <= 200; i++) begin
            if (!bus.doneKey && bus.mode !== 4'd1) mode_bad++;
            @(negedge clk);
            if (bus.loadKey) nload++;
            if (bus.doneKey) begin lat = i; break; end
        end
        n_cmp++; if (nload !== 1) begin n_err++; $display("FAIL key_loadKey_pulses: got %0d want 1", nload); end
        n_cmp++; if (lat !== 68) begin n_err++; $display("FAIL key_latency: got %0d want 68", lat); end
        n_cmp++; if (mode_bad !== 0) begin n_err++; $display("FAIL key_mode_keyexp: got %0d bad cycles want 0", mode_bad); end
        n_cmp++; if (bus.mode !== 4'd2) begin n_err++; $display("FAIL key_mode_ready: got %0d want 2", bus.mode); end
    endtask

    task automatic test_encrypt_kat();
        int nload, lat;
        do_block(PT0, 1'b1, nload, lat);
        n_cmp++; if (nload !== 1) begin n_err++; $display("FAIL enc_loadData_pulses: got %0d want 1", nload); end
        n_cmp++; if (lat !== 72) begin n_err++; $display("FAIL enc_latency: got %0d want 72", lat); end
        n_cmp++; if (bus.outData !== CT0) begin n_err++; $display("FAIL enc_kat: got %h want %h", bus.outData, CT0); end
        n_cmp++; if (bus.mode !== 4'd4) begin n_err++; $display("FAIL enc_mode_done: got %0d want 4", bus.mode); end
        read_pulse();
        n_cmp++; if (bus.doneData !== 1'b0) begin n_err++; $display("FAIL enc_read_clear: got %b want 0", bus.doneData); end
        n_cmp++; if (bus.mode !== 4'd2) begin n_err++; $display("FAIL enc_read_mode: got %0d want 2", bus.mode); end
        n_cmp++; if (bus.outData !== CT0) begin n_err++; $display("FAIL enc_out_hold: got %h want %h", bus.outData, CT0); end
    endtask

    // Decrypt known answer, with a different key requested during RUN.
    task automatic test_decrypt();
        int got, nlk, lat;
        bus.BLOCK = CT0;
        bus.enc_dec = 1'b0;
        bus.newData = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (bus.loadData) got = 1;
        end
        bus.newData = 1'b0;
        bus.KEY = ~KEY0;
        bus.newKey = 1'b1;
        nlk = 0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.loadKey) nlk++;
            if (bus.doneData) begin lat = i; break; end
        end
        bus.newKey = 1'b0;
        bus.KEY = KEY0;
        n_cmp++; if (got !== 1) begin n_err++; $display("FAIL dec_load: got %0d want 1", got); end
        n_cmp++; if (nlk !== 0) begin n_err++; $display("FAIL dec_newKey_ignored: got %0d loadKey want 0", nlk); end
        n_cmp++; if (lat !== 72) begin n_err++; $display("FAIL dec_latency: got %0d want 72", lat); end
        n_cmp++; if (bus.outData !== PT0) begin n_err++; $display("FAIL dec_kat: got %h want %h", bus.outData, PT0); end
        n_cmp++; if (bus.mode !== 4'd4) begin n_err++; $display("FAIL dec_mode_done: got %0d want 4", bus.mode); end
        read_pulse();
    endtask

    task automatic test_back_to_back();
        blk_t pt [5];
        blk_t ct [5];
        blk_t exp_ct;
        int got, lat, early, nload;
        pt[0] = {64'hA8D5F7DE0123FEDC, 64'h01234567FEDCBA98};
        pt[1] = PT0;
        pt[2] = '0;
        pt[3] = '1;
        pt[4] = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
        bus.BLOCK = pt[0];
        bus.enc_dec = 1'b1;
        bus.newData = 1'b1;
        for (int b = 0; b < 5; b++) begin
            got = 0;
            for (int i = 0; i < 20 && got == 0; i++) begin
                @(negedge clk);
                if (bus.loadData) got = 1;
            end
            bus.newData = 1'b0;
            lat = -1;
            for (int i = 1; i <= 200; i++) begin
                @(negedge clk);
                if (bus.doneData) begin lat = i; break; end
            end
            ct[b] = bus.outData;
            exp_ct = simon_model(KEY0, pt[b], 1'b1);
            n_cmp++; if (got !== 1) begin n_err++; $display("FAIL stream_load[%0d]: got %0d want 1", b, got); end
            n_cmp++; if (lat !== 72) begin n_err++; $display("FAIL stream_latency[%0d]: got %0d want 72", b, lat); end
            n_cmp++; if (ct[b] !== exp_ct) begin n_err++; $display("FAIL stream_ct[%0d]: got %h want %h", b, ct[b], exp_ct); end
            if (b < 4) begin
                // Next request raised before the result is read: must stall.
                bus.BLOCK = pt[b+1];
                bus.newData = 1'b1;
                early = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.loadData || !bus.doneData) early++;
                end
                n_cmp++; if (early !== 0) begin n_err++; $display("FAIL stream_stall[%0d]: got %0d early cycles want 0", b, early); end
                n_cmp++; if (bus.outData !== exp_ct) begin n_err++; $display("FAIL stream_hold[%0d]: got %h want %h", b, bus.outData, exp_ct); end
            end
            read_pulse();
        end
        for (int b = 0; b < 5; b++) begin
            do_block(ct[b], 1'b0, nload, lat);
            n_cmp++; if (lat !== 72) begin n_err++; $display("FAIL rt_latency[%0d]: got %0d want 72", b, lat); end
            n_cmp++; if (bus.outData !== pt[b]) begin n_err++; $display("FAIL rt_pt[%0d]: got %h want %h", b, bus.outData, pt[b]); end
            read_pulse();
        end
    endtask

    task automatic test_reset_midrun();
        int got, stalled, ki, di, li, oi;
        bus.BLOCK = PT0;
        bus.enc_dec = 1'b1;
        bus.newData = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (bus.loadData) got = 1;
        end
        bus.newData = 1'b0;
        repeat (10) @(negedge clk);
        nR = 1'b1;
        @(negedge clk);
        nR = 1'b0;
        n_cmp++; if (bus.doneData !== 1'b0) begin n_err++; $display("FAIL mid_doneData: got %b want 0", bus.doneData); end
        n_cmp++; if (bus.doneKey !== 1'b0) begin n_err++; $display("FAIL mid_doneKey: got %b want 0", bus.doneKey); end
        n_cmp++; if (bus.mode !== 4'd0) begin n_err++; $display("FAIL mid_mode: got %0d want 0", bus.mode); end
        bus.newData = 1'b1;
        stalled = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.loadData || bus.mode !== 4'd0) stalled++;
        end
        n_cmp++; if (stalled !== 0) begin n_err++; $display("FAIL mid_no_key_wait: got %0d bad cycles want 0", stalled); end
        // Key and data requested together: key first, data after doneKey.
        bus.KEY = KEY0;
        bus.newKey = 1'b1;
        ki = -1; di = -1; li = -1; oi = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.loadKey && ki < 0) begin ki = i; bus.newKey = 1'b0; end
            if (bus.doneKey && di < 0) di = i;
            if (bus.loadData && li < 0) begin li = i; bus.newData = 1'b0; end
            if (bus.doneData) begin oi = i; break; end
        end
        bus.newKey = 1'b0;
        bus.newData = 1'b0;
        n_cmp++; if (ki !== 1) begin n_err++; $display("FAIL sim_key_first: got %0d want 1", ki); end
        n_cmp++; if (di !== 69) begin n_err++; $display("FAIL sim_doneKey_at: got %0d want 69", di); end
        n_cmp++; if (li !== 70) begin n_err++; $display("FAIL sim_load_at: got %0d want 70", li); end
        n_cmp++; if (oi !== 142) begin n_err++; $display("FAIL sim_done_at: got %0d want 142", oi); end
        n_cmp++; if (bus.outData !== CT0) begin n_err++; $display("FAIL sim_kat: got %h want %h", bus.outData, CT0); end
        read_pulse();
    endtask

    initial begin
        bus.newData  = 1'b0;
        bus.newKey   = 1'b0;
        bus.enc_dec  = 1'b0;
        bus.readData = 1'b0;
        bus.BLOCK    = '0;
        bus.KEY      = '0;
        nR           = 1'b1;
        @(negedge clk);
        test_reset();
        test_key_expand();
        test_encrypt_kat();
        test_decrypt();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
